// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Data-memory load/store engine: req/gnt/rvalid handshake, lane
//            formatting, load extension, misalignment check, transfer timeout.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_byte_i,
  input  logic        zero_extnd_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rd_data_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  localparam logic [1:0] c_sz_byte = 2'b00;
  localparam logic [1:0] c_sz_half = 2'b01;

  logic [1:0]         r_state;
  logic [29:0]        r_waddr;
  logic               r_we;
  logic [1:0]         r_size;
  logic               r_zext;
  logic [1:0]         r_off;
  logic [3:0]         r_be;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic [c_cnt_w-1:0] r_cnt;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_bad_align;
  logic        w_accept;
  logic        w_in_req;
  logic        w_in_done;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Request formatting; loads drive the full byte mask
  always_comb begin
    w_be        = 4'b1111;
    w_wdata     = wr_data_i;
    w_bad_align = 1'b0;
    case (data_byte_i)
      c_sz_byte: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wr_data_i[7:0]}};
      end
      c_sz_half: begin
        w_be        = 4'b0011 << addr_i[1:0];
        w_wdata     = {2{wr_data_i[15:0]}};
        w_bad_align = addr_i[0];
      end
      default: begin
        w_bad_align = |addr_i[1:0];
      end
    endcase
    if (!data_wr_i) begin
      w_be = 4'b1111;
    end
  end

  assign w_accept = (r_state == c_st_idle) && data_req_i && !w_bad_align;

  // Load extraction from the latched offset/size
  always_comb begin
    w_byte = mem_rdata_i[7:0];
    case (r_off)
      2'd1:    w_byte = mem_rdata_i[15:8];
      2'd2:    w_byte = mem_rdata_i[23:16];
      2'd3:    w_byte = mem_rdata_i[31:24];
      default: w_byte = mem_rdata_i[7:0];
    endcase
    w_half = r_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (r_size)
      c_sz_byte: w_load = {{24{w_byte[7] & ~r_zext}}, w_byte};
      c_sz_half: w_load = {{16{w_half[15] & ~r_zext}}, w_half};
      default:   w_load = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_waddr <= '0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_zext  <= 1'b0;
      r_off   <= 2'b00;
      r_be    <= 4'b0000;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_waddr <= addr_i[31:2];
            r_we    <= data_wr_i;
            r_size  <= data_byte_i;
            r_zext  <= zero_extnd_i;
            r_off   <= addr_i[1:0];
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_state <= c_st_req;
          end
        end
        c_st_req: begin
          // A grant on the last allowed cycle still wins over the timeout
          if (mem_gnt_i) begin
            r_cnt   <= '0;
            r_state <= r_we ? c_st_done : c_st_resp;
          end else if (r_cnt == c_cnt_last) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= c_st_done;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        c_st_resp: begin
          if (mem_rvalid_i) begin
            r_rdata <= w_load;
            r_state <= c_st_done;
          end else if (r_cnt == c_cnt_last) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= c_st_done;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        default: begin
          r_err   <= 1'b0;
          r_rdata <= '0;
          r_cnt   <= '0;
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign w_in_req  = (r_state == c_st_req);
  assign w_in_done = (r_state == c_st_done);

  // Bus fields are only driven while the request is outstanding
  assign mem_req_o   = w_in_req;
  assign mem_we_o    = w_in_req & r_we;
  assign mem_addr_o  = w_in_req ? {r_waddr, 2'b00} : 32'h0;
  assign mem_be_o    = w_in_req ? r_be : 4'b0000;
  assign mem_wdata_o = w_in_req ? r_wdata : 32'h0;

  // reset gates the IDLE-state combinational outputs so all outputs read 0
  assign stall_o      = !reset && (w_accept || w_in_req || (r_state == c_st_resp));
  assign misaligned_o = !reset && (r_state == c_st_idle) && data_req_i && w_bad_align;
  assign done_o       = w_in_done;
  assign bus_err_o    = w_in_done & r_err;
  assign rd_data_o    = w_in_done ? r_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Scoreboard bench for load_store_unit with a randomised bus model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_req_i, data_wr_i, zero_extnd_i;
  logic [1:0]  data_byte_i;
  logic [31:0] addr_i, wr_data_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o, done_o, misaligned_o, bus_err_o;
  logic [31:0] rd_data_o;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .data_req_i(data_req_i), .data_wr_i(data_wr_i), .data_byte_i(data_byte_i),
    .zero_extnd_i(zero_extnd_i), .addr_i(addr_i), .wr_data_i(wr_data_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .done_o(done_o), .rd_data_o(rd_data_o),
    .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mis;
    logic        we;
    logic [31:0] waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
    int          stall;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Bus-model controls for the transaction in flight
  int          cur_gnt = 0, cur_rv = 0;
  logic [31:0] cur_rdata = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: sizes in bytes, shifts and masks over the whole word
  function automatic exp_t model(input logic we, input logic [1:0] sz, input logic zx,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rdat, input int gd, input int rdl);
    exp_t        e;
    int          nbytes, off;
    logic [63:0] mask;
    logic [31:0] val;
    nbytes  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off     = int'(a[1:0]);
    mask    = (64'h1 << (8 * nbytes)) - 64'h1;
    e.mis   = (int'(a % 32'(nbytes)) != 0);
    e.we    = we;
    e.waddr = a & ~32'h3;
    e.be    = we ? 4'(((1 << nbytes) - 1) << off) : 4'hF;
    e.wdata = (nbytes == 1) ? 32'(wd[7:0]) * 32'h01010101 :
              (nbytes == 2) ? 32'(wd[15:0]) * 32'h00010001 : wd;
    e.err   = (gd >= TO) || (!we && rdl >= TO);
    val     = (rdat >> (8 * off)) & mask[31:0];
    if (nbytes < 4 && !zx && val[8 * nbytes - 1]) val = val | ~mask[31:0];
    e.rd    = (we || e.err) ? 32'h0 : val;
    if (e.mis)         e.stall = 0;
    else if (gd >= TO) e.stall = 1 + TO;
    else               e.stall = 1 + (gd + 1) + (we ? 0 : ((rdl >= TO) ? TO : rdl + 1));
    return e;
  endfunction

  // Bus responder: grant after cur_gnt request cycles, rvalid after cur_rv RESP cycles
  initial begin
    int          req_cyc, rwait, resp_dly;
    logic        resp_active;
    logic [31:0] resp_data;
    req_cyc = 0; rwait = 0; resp_dly = 0; resp_active = 0; resp_data = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    forever begin
      @(posedge clk); #1;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = $urandom;
      if (resp_active) begin
        if (rwait == resp_dly) begin
          mem_rvalid_i = 1; mem_rdata_i = resp_data; resp_active = 0;
        end else rwait++;
      end else if ($urandom_range(0, 3) == 0) begin
        mem_rvalid_i = 1;
      end
      if (mem_req_o) begin
        if (req_cyc == cur_gnt) begin
          mem_gnt_i = 1;
          if (!mem_we_o) begin
            resp_active = 1; rwait = 0; resp_dly = cur_rv; resp_data = cur_rdata;
          end
        end
        req_cyc++;
      end else req_cyc = 0;
    end
  end

  // Monitor: checks bus fields while requesting, pops on completion/misalignment
  initial begin
    exp_t e;
    int   stall_cnt;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) stall_cnt = 0;
      else begin
        if (stall_o) stall_cnt++;
        if (mem_req_o) begin
          if (exp_q.size() == 0) chk("unexpected_req", 32'(mem_req_o), 32'h0);
          else begin
            chk("req_on_misaligned", 32'(exp_q[0].mis), 32'h0);
            chk("mem_addr", mem_addr_o, exp_q[0].waddr);
            chk("mem_be", 32'(mem_be_o), 32'(exp_q[0].be));
            chk("mem_we", 32'(mem_we_o), 32'(exp_q[0].we));
            if (exp_q[0].we) chk("mem_wdata", mem_wdata_o, exp_q[0].wdata);
          end
        end
        if (!done_o) begin
          chk("rd_data_idle", rd_data_o, 32'h0);
          chk("bus_err_idle", 32'(bus_err_o), 32'h0);
        end
        if (done_o || misaligned_o) begin
          if (exp_q.size() == 0) chk("unexpected_done", 32'(done_o), 32'h0);
          else begin
            e = exp_q.pop_front();
            chk("misaligned", 32'(misaligned_o), 32'(e.mis));
            chk("done", 32'(done_o), 32'(!e.mis));
            chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
            if (!e.mis) begin
              chk("rd_data", rd_data_o, e.rd);
              chk("bus_err", 32'(bus_err_o), 32'(e.err));
            end
          end
          stall_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic zx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdat, input int gd, input int rdl);
    exp_t e;
    int   n;
    e = model(we, sz, zx, a, wd, rdat, gd, rdl);
    cur_gnt = gd; cur_rv = rdl; cur_rdata = rdat;
    data_req_i = 1; data_wr_i = we; data_byte_i = sz; zero_extnd_i = zx;
    addr_i = a; wr_data_i = wd;
    exp_q.push_back(e);
    if (e.mis) begin
      @(posedge clk); #1;
    end else begin
      n = 0;
      do begin @(negedge clk); n++; end while (!done_o && n < 200);
      if (!done_o) begin
        chk("done_timeout", 32'(done_o), 32'h1);
        exp_q.delete();
      end
      // data_req_i stays high through DONE, which must not start a new access
      @(posedge clk); #1;
    end
    data_req_i = 0;
    if (e.err) repeat (4) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic        t_we, t_zx;
    logic [1:0]  t_sz;
    logic [31:0] t_a;
    int          k, gd, rdl;
    reset = 1; data_req_i = 0; data_wr_i = 0; data_byte_i = 0; zero_extnd_i = 0;
    addr_i = 0; wr_data_i = 0;
    repeat (2) @(posedge clk);
    #2;
    data_req_i = 1;
    #1;
    chk("reset_outputs", 32'({mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        stall_o, done_o, rd_data_o, misaligned_o, bus_err_o} != 0), 32'h0);
    data_req_i = 0;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    issue(0, 2'b00, 0, 32'h103, 32'h0, 32'h80112233, 0, 0);   // LB
    issue(0, 2'b00, 1, 32'h103, 32'h0, 32'h80112233, 0, 0);   // LBU
    issue(0, 2'b01, 1, 32'h102, 32'h0, 32'hBEEF1234, 0, 0);   // LHU
    issue(0, 2'b01, 0, 32'h100, 32'h0, 32'hBEEF1234, 0, 0);   // LH
    issue(1, 2'b00, 0, 32'h201, 32'hA5, 32'h0, 0, 0);         // SB
    issue(0, 2'b10, 0, 32'h102, 32'h0, 32'h0, 0, 0);          // LW misaligned
    issue(1, 2'b01, 0, 32'h203, 32'h1234, 32'h0, 0, 0);       // SH misaligned
    issue(0, 2'b10, 0, 32'h104, 32'h0, 32'hCAFEF00D, 3, 2);   // delayed gnt/rvalid
    issue(0, 2'b10, 0, 32'h108, 32'h0, 32'h12345678, 20, 0);  // no grant
    issue(0, 2'b10, 0, 32'h10C, 32'h0, 32'h12345678, 0, 17);  // no rvalid
    issue(1, 2'b10, 0, 32'h110, 32'h89ABCDEF, 32'h0, 15, 0);  // grant on last cycle
    issue(0, 2'b11, 0, 32'h114, 32'h0, 32'h87654321, 0, 15);  // rvalid on last cycle
    issue(1, 2'b01, 0, 32'h222, 32'h0000C3D4, 32'h0, 1, 0);   // SH upper half

    // Reset while waiting in RESP: no completion, late rvalid ignored
    cur_gnt = 0; cur_rv = 10; cur_rdata = 32'h55AA55AA;
    data_req_i = 1; data_wr_i = 0; data_byte_i = 2'b10; zero_extnd_i = 0;
    addr_i = 32'h400; wr_data_i = 0;
    exp_q.push_back(model(0, 2'b10, 0, 32'h400, 32'h0, 32'h55AA55AA, 0, 10));
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1;
    #1;
    data_req_i = 0;
    exp_q.delete();
    chk("reset_mid_access", 32'({mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        stall_o, done_o, rd_data_o, misaligned_o, bus_err_o} != 0), 32'h0);
    @(posedge clk); #3;
    reset = 0;
    repeat (14) begin @(posedge clk); #1; end
    issue(0, 2'b10, 0, 32'h300, 32'h0, 32'h0BADCAFE, 0, 0);

    for (int i = 0; i < 150; i++) begin
      t_we = 1'($urandom); t_zx = 1'($urandom); t_sz = 2'($urandom);
      t_a  = {20'h0, 12'($urandom)};
      k = $urandom_range(0, 15);
      gd  = (k == 0) ? 15 : (k == 1) ? 16 : $urandom_range(0, 3);
      k = $urandom_range(0, 15);
      rdl = (k == 0) ? 15 : (k == 1) ? 17 : $urandom_range(0, 3);
      issue(t_we, t_sz, t_zx, t_a, $urandom, $urandom, gd, rdl);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
